aes_inv_cipher_iter: RTL and testbench

//  Iterative AES inverse cipher (decrypt) engine; the decrypt-side counterpart of the encrypt datapath.

---
 rtl/aes_inv_cipher_iter_if.sv | 25 ++
 rtl/aes_inv_cipher_iter.sv | 133 +++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_if.sv
// Valid/ready bundle between a block source/sink and the iterative AES decrypt engine.
// The key schedule width follows from the round count and is not meant to be overridden.
interface aes_inv_cipher_iter_if #(
  parameter int NR = 10
);
  localparam int KS_W = 128*(NR+1);

  logic            in_valid;
  logic            in_ready;
  logic [127:0]    in_data;
  logic [KS_W-1:0] key_sched;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_data;

  modport master (
    output in_valid, in_data, key_sched, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, key_sched, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock over a caller-supplied key schedule.
//   state | meaning
//   IDLE  | waiting for a ciphertext block, in_ready high
//   BUSY  | applying inverse rounds rnd..0, one per clock
//   DONE  | plaintext held in state register until out_ready
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_cipher_iter_if.slave bus
);
  localparam int KS_W = 128*(NR+1);
  localparam int RW   = $clog2(NR);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t          fsm, fsm_nxt;
  logic [127:0]  state_q, state_nxt, round_out;
  logic [RW-1:0] rnd, rnd_nxt;
  logic [127:0]  rk [NR+1];

  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign rk[g] = bus.key_sched[KS_W-1-128*g -: 128];
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant built only from bits of {1,2,4,8}; enough for 09/0b/0d/0e.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = INV_SBOX[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [3:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    coef = '{4'he, 4'hb, 4'hd, 4'h9};
    o    = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gm(s[127-8*(4*c+j) -: 8], coef[(j-r+4)%4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  // Last round (rnd==0) skips InvMixColumns.
  always_comb begin
    round_out = inv_sub(inv_shift(state_q)) ^ rk[rnd];
    if (rnd != '0) round_out = inv_mix(round_out);
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state_q;
    rnd_nxt   = rnd;
    unique case (fsm)
      IDLE: if (bus.in_valid) begin
        fsm_nxt   = BUSY;
        state_nxt = bus.in_data ^ rk[NR];
        rnd_nxt   = RW'(NR-1);
      end
      BUSY: begin
        state_nxt = round_out;
        if (rnd == '0) fsm_nxt = DONE;
        else           rnd_nxt = rnd - RW'(1);
      end
      DONE: if (bus.out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      state_q <= '0;
      rnd     <= '0;
    end else begin
      fsm     <= fsm_nxt;
      state_q <= state_nxt;
      rnd     <= rnd_nxt;
    end
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.out_valid = (fsm == DONE);
  assign bus.out_data  = state_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for the iterative AES decrypt engine: known-answer table, corner sequences, and a
// random stream whose ciphertexts come from a forward-cipher model built here.
module tb_aes_inv_cipher_iter;
  localparam int NR   = 10;
  localparam int KS_W = 128*(NR+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_inv_cipher_iter_if #(.NR(NR)) bus ();
  aes_inv_cipher_iter #(.NR(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] sbox [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [3];

  logic [127:0] t6_pt [50];
  logic [127:0] t6_key [50];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Forward S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [KS_W-1:0] expand(input logic [127:0] key);
    logic [31:0]     w [4*(NR+1)];
    logic [31:0]     t;
    logic [7:0]      rc;
    logic [KS_W-1:0] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 4*(NR+1); i++) ks[KS_W-1-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [KS_W-1:0] ks);
    logic [127:0] s, o;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    s = pt ^ ks[KS_W-1 -: 128];
    for (int rd = 1; rd <= NR; rd++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox[s[127-8*k -: 8]];
      o = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      s = o;
      if (rd < NR) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
              acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], coef[(j-r+4)%4]);
            o[127-8*(4*c+r) -: 8] = acc;
          end
        s = o;
      end
      s = s ^ ks[KS_W-1-128*rd -: 128];
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Offer one block, return the plaintext and the accept-to-valid clock count; out_ready left low.
  task automatic do_block(input logic [127:0] ct, input logic [KS_W-1:0] ks,
                          output logic [127:0] data, output int lat);
    int guard;
    guard = 0;
    bus.in_data   = ct;
    bus.key_sched = ks;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.in_ready) chk("accept_timeout", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    data = bus.out_data;
  endtask

  initial begin
    logic [127:0] got, held;
    int lat, cnt, guard;

    build_sbox();
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_sched = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    rst_n = 1'b1;
    tick();

    // Known-answer table
    for (int i = 0; i < 3; i++) begin
      do_block(vecs[i].ct, expand(vecs[i].key), got, lat);
      chk($sformatf("kat%0d_data", i), got, vecs[i].pt);
      chk($sformatf("kat%0d_latency", i), 128'(lat), 128'd10);
      drain();
    end

    // Backpressure: plaintext and in_ready held for 5 clocks, IDLE one clock after out_ready
    do_block(vecs[0].ct, expand(vecs[0].key), held, lat);
    chk("bp_data", held, vecs[0].pt);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", bus.out_data, held);
      chk("bp_in_ready", 128'({bus.in_ready, bus.out_valid}), 128'b01);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", 128'({bus.in_ready, bus.out_valid}), 128'b10);
    bus.out_ready = 1'b0;

    // Stray all-ones block offered while busy must be ignored
    bus.in_data   = vecs[0].ct;
    bus.key_sched = expand(vecs[0].key);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (lat == 3) begin
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("busy_ign_data", bus.out_data, vecs[0].pt);
    chk("busy_ign_latency", 128'(lat), 128'd10);
    drain();
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.in_ready && !bus.out_valid) cnt++;
    end
    chk("busy_ign_no_stray", 128'(cnt), 128'd12);

    // Asynchronous reset four clocks into a block
    bus.in_data   = vecs[1].ct;
    bus.key_sched = expand(vecs[1].key);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_out_data", bus.out_data, 128'd0);
    chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.out_valid || !bus.in_ready) cnt++;
    end
    chk("midrst_no_spurious", 128'(cnt), 128'd0);
    do_block(vecs[1].ct, expand(vecs[1].key), got, lat);
    chk("midrst_after_data", got, vecs[1].pt);
    chk("midrst_after_latency", 128'(lat), 128'd10);
    drain();

    // Random stream, in_valid and out_ready held high: one block every NR+2 clocks
    for (int i = 0; i < 50; i++) begin
      t6_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
      t6_key[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.out_ready = 1'b1;
    bus.key_sched = expand(t6_key[0]);
    bus.in_data   = encrypt(t6_pt[0], bus.key_sched);
    bus.in_valid  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.in_ready) chk("stream_start_timeout", 128'(bus.in_ready), 128'd1);
    for (int i = 0; i < 50; i++) begin
      tick();
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
        tick();
        lat++;
      end
      chk($sformatf("stream%0d_data", i), bus.out_data, t6_pt[i]);
      chk($sformatf("stream%0d_latency", i), 128'(lat), 128'd10);
      if (i < 49) begin
        bus.key_sched = expand(t6_key[i+1]);
        bus.in_data   = encrypt(t6_pt[i+1], bus.key_sched);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      chk($sformatf("stream%0d_idle", i), 128'({bus.in_ready, bus.out_valid}), 128'b10);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
